// File: rtl/dcache_arbiter.sv
// dcache_arbiter: two-port round-robin sequencer sharing the single data-cache port
module dcache_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] c_address,
  output logic [WIDTH-1:0] c_data_in,
  output logic             c_read,
  output logic             c_write,
  input  logic [WIDTH-1:0] c_data_out
);
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
  state_t state, next;
  logic last, l_we, busy;
  logic [WIDTH-1:0] l_addr, l_wdata;
  always_comb begin
    next = IDLE;
    if (state == IDLE)
      next = (req0 && req1) ? (last ? BUSY0 : BUSY1) : req0 ? BUSY0 : req1 ? BUSY1 : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      last    <= 1'b1;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      l_we    <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
    end else begin
      state <= next;
      ack0  <= state == BUSY0;
      ack1  <= state == BUSY1;
      if (next == BUSY0) begin
        l_we    <= we0;
        l_addr  <= addr0;
        l_wdata <= wdata0;
      end
      if (next == BUSY1) begin
        l_we    <= we1;
        l_addr  <= addr1;
        l_wdata <= wdata1;
      end
      if (state == BUSY0) begin
        last <= 1'b0;
        if (!l_we) rdata0 <= c_data_out;
      end
      if (state == BUSY1) begin
        last <= 1'b1;
        if (!l_we) rdata1 <= c_data_out;
      end
    end
  end
  assign busy      = state != IDLE;
  assign gnt0      = state == BUSY0 && !RST;
  assign gnt1      = state == BUSY1 && !RST;
  assign c_write   = busy && l_we && !RST;
  assign c_read    = busy && !l_we && !RST;
  assign c_address = busy ? l_addr : '0;
  assign c_data_in = busy ? l_wdata : '0;
endmodule

// File: doc/dcache_arbiter.md
# dcache_arbiter

Two-port round-robin arbiter and sequencer for the 8-word data cache. It shares the cache's single address/data/read/write port between two requesters: port 0 is the pipeline MEM stage, port 1 is the debug/loader port. It grants one access at a time, drives the cache control signals for exactly one cycle per access, and returns registered read data with a one-cycle acknowledge.

## Interface
- WIDTH, 32, data and address width.

- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset; synchronous, active-high.
- req0 / req1  in  1  access request; held high until the matching gnt is seen.
- we0 / we1  in  1  1 = write, 0 = read; valid while req is high.
- addr0 / addr1  in  WIDTH  byte address; the cache uses bits [4:2].
- wdata0 / wdata1  in  WIDTH  write data.
- gnt0 / gnt1  out  1  high for the single cycle in which the port's access drives the cache.
- ack0 / ack1  out  1  one-cycle pulse in the cycle after gnt; marks completion of a read or write.
- rdata0 / rdata1  out  WIDTH  registered read data; valid while ack is high after a read, and held until the port's next read ack.
- c_address  out  WIDTH  cache address.
- c_data_in  out  WIDTH  cache write data.
- c_read  out  1  cache read strobe.
- c_write  out  1  cache write strobe.
- c_data_out  in  WIDTH  combinational cache read data.

## Operation
- The FSM has three states: IDLE, BUSY0, BUSY1. The reset state is IDLE.
- **IDLE state:**
  - With no request, stay in IDLE.
  - With exactly one req high, go to BUSY of that port.
  - With both req high, grant the port other than `last`.
  - On the transition, latch we, addr and wdata of the winning port into internal registers.
- **BUSY0 / BUSY1 states:**
  - Drive c_address = latched addr and c_data_in = latched wdata.
  - Drive c_write = latched we and c_read = ~latched we.
  - Assert gnt of the owning port.
  - On the next edge:
    - Set `last` to the owner.
    - Pulse the owner's ack.
    - If the access is a read, load the owner's rdata from c_data_out.
    - Return unconditionally to IDLE.
- `last` is a 1-bit round-robin pointer. It resets to 1, so port 0 wins the first tie.
- In IDLE, all cache outputs are 0: c_read, c_write, c_address and c_data_in.
- gnt0, gnt1, c_read and c_write are decoded from the state register and gated with ~RST. A reset cycle therefore never issues a cache write.
- Requests are never pre-empted. The non-owning port's req and data are ignored while BUSY.

## Timing
- **Reset values:**
  - gnt0 = gnt1 = ack0 = ack1 = 0.
  - rdata0 = rdata1 = 0.
  - All c_* outputs = 0.
  - state = IDLE, last = 1.
- **Latency for an access:**
  - req sampled high in cycle t (IDLE).
  - gnt and cache strobes are high in cycle t+1.
  - ack is high and rdata is valid in cycle t+2.
- **Requester rule:** on the edge ending a gnt cycle, the requester deasserts req, or presents its next request. Any req high while the FSM is in IDLE is treated as a new request.
- **Throughput:** at most one access every 2 cycles. With both ports saturated, grants alternate 0,1,0,1.
- **Simultaneous events:** an ack of one port may coincide with the FSM sitting in IDLE and arbitrating. Back-to-back accesses therefore produce gnt every other cycle with no bubble beyond the IDLE cycle.
- **Reset during BUSY:**
  - The access is abandoned: no ack, no rdata update, c_write held low.
  - The FSM is in IDLE in the cycle after RST.
  - `last` returns to 1.
- **Reset during IDLE:** any pending req is ignored and must be re-sampled after RST drops.
- **Address handling:** addresses are passed through unmodified with no alignment check. Width is exactly WIDTH everywhere and there is no arithmetic.

## Test plan
- **Reset:** assert RST for 2 cycles, then req0 = req1 = 1 (reads) in the same cycle.
  - All outputs are 0 during reset.
  - First gnt0 arrives one cycle later, then gnt1 two cycles after that.
- **Write then read:**
  - Port 0 writes addr 0x0C, wdata 0xDEADBEEF → cycle t+1 shows c_write = 1, c_address = 0x0C, c_data_in = 0xDEADBEEF; ack0 in t+2.
  - Port 1 then reads 0x0C → ack1 with rdata1 = 0xDEADBEEF.
- **Read of reset contents:** after reset, port 1 reads addr 0x14 → c_read = 1 during gnt1; rdata1 = 0x00000005 on ack1.
- **Saturation:** both ports hold req high for 12 cycles, re-requesting immediately.
  - Grants strictly alternate 0,1,0,1 with a gnt every 2nd cycle.
  - Six grants in total, three per port.
- **Single-port streaming:** only req1 is high, with 4 back-to-back reads of 0x00, 0x04, 0x08, 0x1C.
  - gnt1 comes every other cycle regardless of `last`.
  - rdata1 = 0, 1, 2, 7.
- **Reset mid-write:** port 0 writes 0x10, data 0xFFFFFFFF, and RST is asserted in the gnt0 cycle.
  - c_write = 0 in that cycle and no ack0 follows.
  - A following port 0 read of 0x10 returns 0x00000004.
